// File: rtl/pix_sink.sv
// pix_sink: strobe/ack pixel-byte sink with FIFO, VGA timing and 2-bit RGB output.
// Optional feature macro: PIX_SINK_UNDERFLOW_RESYNC_EN (underflow drops back to FILL).
module pix_sink #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PREFILL = 8,
  parameter int HA_END  = 639,
  parameter int HS_STA  = 655,
  parameter int HS_END  = 751,
  parameter int LINE    = 799,
  parameter int VA_END  = 479,
  parameter int VS_STA  = 489,
  parameter int VS_END  = 491,
  parameter int SCREEN  = 524
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_i,
  input  logic              stb_i,
  output logic              ack_o,
  output logic [1:0]        vga_r,
  output logic [1:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [9:0]        sx,
  output logic [9:0]        sy,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       underflow_cnt,
  output logic              dbg_state
);

  localparam logic [9:0]        HA_END_C  = 10'(HA_END);
  localparam logic [9:0]        HS_STA_C  = 10'(HS_STA);
  localparam logic [9:0]        HS_END_C  = 10'(HS_END);
  localparam logic [9:0]        LINE_C    = 10'(LINE);
  localparam logic [9:0]        VA_END_C  = 10'(VA_END);
  localparam logic [9:0]        VS_STA_C  = 10'(VS_STA);
  localparam logic [9:0]        VS_END_C  = 10'(VS_END);
  localparam logic [9:0]        SCREEN_C  = 10'(SCREEN);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   PREFILL_C = (ADDR_W+1)'(PREFILL);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic {ST_FILL = 1'b0, ST_STREAM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [9:0]          hc_q, hc_d, vc_q, vc_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                ack_q, ack_d;
  logic [5:0]          rgb_q, rgb_d;
  logic                hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [9:0]          sx_q, sx_d, sy_q, sy_d;
  logic [15:0]         uf_q, uf_d;
  logic [5:0]          mem_q [DEPTH];

  logic active, frame_start, go, push, pop, under;

  // Handshake: a byte transfers on a posedge where stb_i && ack_o. ack_o is
  // registered and reflects space after this cycle's push and pop, so a full
  // FIFO deasserts it for the following edge and the writer must hold its byte.
  always_comb begin
    active      = (hc_q <= HA_END_C) && (vc_q <= VA_END_C);
    frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
    go          = (state_q == ST_STREAM) || (frame_start && (level_q >= PREFILL_C));
    push        = stb_i && ack_q;
    pop         = go && active && (level_q != '0);
    under       = go && active && (level_q == '0);

    hc_d = (hc_q == LINE_C) ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == LINE_C) vc_d = (vc_q == SCREEN_C) ? 10'd0 : vc_q + 10'd1;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    ack_d = (level_d < DEPTH_C);

    state_d = state_q;
    if (go) state_d = ST_STREAM;
`ifdef PIX_SINK_UNDERFLOW_RESYNC_EN
    // Losing a pixel abandons the frame; the next frame start realigns it.
    if (under) state_d = ST_FILL;
`endif

    uf_d = uf_q;
    if (under && (uf_q != 16'hFFFF)) uf_d = uf_q + 16'd1;

    rgb_d = pop ? mem_q[rd_ptr_q] : 6'd0;
    hs_d  = !((hc_q >= HS_STA_C) && (hc_q < HS_END_C));
    vs_d  = !((vc_q >= VS_STA_C) && (vc_q < VS_END_C));
    de_d  = active;
    sx_d  = hc_q;
    sy_d  = vc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      hc_q     <= 10'd0;
      vc_q     <= 10'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ack_q    <= 1'b0;
      rgb_q    <= 6'd0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      sx_q     <= 10'd0;
      sy_q     <= 10'd0;
      uf_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ack_q    <= ack_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      uf_q     <= uf_d;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i[7:2];
  end

  assign ack_o         = ack_q;
  assign vga_r         = rgb_q[5:4];
  assign vga_g         = rgb_q[3:2];
  assign vga_b         = rgb_q[1:0];
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign de            = de_q;
  assign sx            = sx_q;
  assign sy            = sy_q;
  assign fifo_level    = level_q;
  assign underflow_cnt = uf_q;
  assign dbg_state     = (state_q == ST_STREAM);

endmodule

// File: tb/tb_pix_sink.sv
// tb_pix_sink: randomized and directed bench for pix_sink on a reduced screen geometry,
// checked every cycle against a queue-based frame model.
module tb_pix_sink;

  localparam int HA = 15, HSS = 19, HSE = 23, LN = 27;
  localparam int VA = 5, VSS = 7, VSE = 8, SCR = 9;
  localparam int H = LN + 1, V = SCR + 1, FRAME = H * V;
  localparam int DEPTH = 16, PREFILL = 8;
`ifdef PIX_SINK_UNDERFLOW_RESYNC_EN
  localparam bit RESYNC = 1'b1;
  localparam int UF_TARGET = 1;
`else
  localparam bit RESYNC = 1'b0;
  localparam int UF_TARGET = 10;
`endif

  logic        clk, rst, stb_i, ack_o, hsync, vsync, de, dbg_state;
  logic [7:0]  data_i;
  logic [1:0]  vga_r, vga_g, vga_b;
  logic [9:0]  sx, sy;
  logic [4:0]  fifo_level;
  logic [15:0] underflow_cnt;

  pix_sink #(
    .DEPTH(DEPTH), .ADDR_W(4), .PREFILL(PREFILL),
    .HA_END(HA), .HS_STA(HSS), .HS_END(HSE), .LINE(LN),
    .VA_END(VA), .VS_STA(VSS), .VS_END(VSE), .SCREEN(SCR)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .stb_i(stb_i), .ack_o(ack_o),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
    .de(de), .sx(sx), .sy(sy), .fifo_level(fifo_level),
    .underflow_cnt(underflow_cnt), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0] exp_q[$];
  int         pos;
  bit         m_stream, m_ack, m_pushed;
  logic [5:0] e_rgb;
  logic       e_hs, e_vs, e_de;
  int         e_sx, e_sy, e_uf;

  int  n_cmp, n_err;
  int  mode, rate;
  bit  have_byte, xfer_seen;
  logic [7:0] inc_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Frame position is one integer; row/column fall out of div/mod.
  task automatic model_step();
    int hc, vc;
    bit act, go, under;
    logic [7:0] px;
    m_pushed = 1'b0;
    if (rst) begin
      exp_q.delete();
      pos = 0; m_stream = 0; m_ack = 0;
      e_rgb = '0; e_hs = 1; e_vs = 1; e_de = 0; e_sx = 0; e_sy = 0; e_uf = 0;
      return;
    end
    hc = pos % H;
    vc = pos / H;
    act = (hc <= HA) && (vc <= VA);
    go = m_stream || (pos == 0 && exp_q.size() >= PREFILL);
    under = 0;
    px = '0;
    if (go && act) begin
      if (exp_q.size() > 0) px = exp_q.pop_front();
      else under = 1;
    end
    if (stb_i && m_ack) begin
      exp_q.push_back(data_i);
      m_pushed = 1'b1;
    end
    m_ack = (exp_q.size() < DEPTH);
    m_stream = go && !(RESYNC && under);
    e_rgb = px[7:2];
    e_hs = !(hc >= HSS && hc < HSE);
    e_vs = !(vc >= VSS && vc < VSE);
    e_de = act;
    e_sx = hc;
    e_sy = vc;
    if (under && e_uf < 65535) e_uf++;
    pos = (pos + 1) % FRAME;
  endtask

  task automatic compare_all();
    check("vga_r", 32'(vga_r), 32'(e_rgb[5:4]));
    check("vga_g", 32'(vga_g), 32'(e_rgb[3:2]));
    check("vga_b", 32'(vga_b), 32'(e_rgb[1:0]));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("de", 32'(de), 32'(e_de));
    check("sx", 32'(sx), 32'(e_sx));
    check("sy", 32'(sy), 32'(e_sy));
    check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
    check("ack_o", 32'(ack_o), 32'(m_ack));
    check("underflow_cnt", 32'(underflow_cnt), 32'(e_uf));
    check("state", 32'(dbg_state), 32'(m_stream));
  endtask

  // driver tasks
  task automatic drive();
    case (mode)
      1: begin
        if (!have_byte) begin data_i = inc_val; inc_val = inc_val + 8'h04; have_byte = 1; end
        stb_i = 1'b1;
      end
      2: begin
        if (!have_byte) begin data_i = 8'hE4; have_byte = 1; end
        stb_i = 1'b1;
      end
      3: begin
        if (!have_byte && $urandom_range(0, 99) < rate) begin
          data_i = 8'($urandom);
          have_byte = 1;
        end
        stb_i = have_byte;
      end
      default: stb_i = 1'b0;
    endcase
  endtask

  task automatic tick();
    drive();
    xfer_seen = stb_i && ack_o;
    @(posedge clk);
    model_step();
    if (m_pushed) have_byte = 0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_xfer, cnt, i1, i2, de_cnt, hs_cnt, vs_cnt;
    bit found;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; stb_i = 1'b0; data_i = 8'h00;
    mode = 0; rate = 50; have_byte = 0; inc_val = 8'h00;
    @(negedge clk);

    // reset values
    run(2);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_de", 32'(de), 0);
    check("rst_sxsy", 32'({sx, sy}), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    run(2);
    check("ack_after_rst", 32'(ack_o), 1);
    check("level_after_rst", 32'(fifo_level), 0);

    // backpressure away from frame start
    mode = 1;
    n_xfer = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (xfer_seen) n_xfer++;
    end
    check("bp_transfers", 32'(n_xfer), 16);
    check("bp_ack_low", 32'(ack_o), 0);
    check("bp_level_full", 32'(fifo_level), 16);

    // drain the held stream through one frame start, then reset mid-frame
    run(FRAME - 24 + FRAME + 100);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("midrst_level", 32'(fifo_level), 0);
    check("midrst_state", 32'(dbg_state), 0);
    have_byte = 0;

    // constant-colour stream from frame start
    mode = 2;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (m_stream && e_de && e_sx == 0 && e_sy == 0) found = 1;
    end
    check("stream_start_seen", 32'(found), 1);
    check("first_de", 32'(de), 1);
    check("first_r", 32'(vga_r), 3);
    check("first_g", 32'(vga_g), 2);
    check("first_b", 32'(vga_b), 1);
    check("first_sxsy", 32'({sx, sy}), 0);
    cnt = (de && vga_r == 2'd3) ? 1 : 0;
    for (int i = 0; i < LN; i++) begin
      tick();
      if (de && vga_r == 2'd3) cnt++;
    end
    check("line_pixels", 32'(cnt), HA + 1);

    // writer stall mid-line
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (pos == 2 * H + 4) found = 1;
    end
    check("stall_point_seen", 32'(found), 1);
    mode = 0;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (e_uf == UF_TARGET) found = 1;
    end
    check("underflow_reached", 32'(found), 1);
    check("underflow_cnt_dir", 32'(underflow_cnt), UF_TARGET);
    check("underflow_state", 32'(dbg_state), RESYNC ? 0 : 1);
    mode = 2;
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (de && vga_r == 2'd3 && vga_g == 2'd2 && vga_b == 2'd1) found = 1;
    end
    check("colour_resumed", 32'(found), 1);

    // one full frame of timing
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (pos == 0) found = 1;
    end
    check("frame_align_seen", 32'(found), 1);
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; i1 = -1; i2 = -1;
    for (int i = 1; i <= FRAME + 1; i++) begin
      tick();
      if (i <= FRAME) begin
        if (de) de_cnt++;
        if (!hsync) hs_cnt++;
        if (!vsync) vs_cnt++;
      end
      if (sx == 10'd0 && sy == 10'd0) begin
        if (i1 < 0) i1 = i;
        else if (i2 < 0) i2 = i;
      end
    end
    check("frame_de_cycles", 32'(de_cnt), (HA + 1) * (VA + 1));
    check("frame_hsync_low", 32'(hs_cnt), (HSE - HSS) * V);
    check("frame_vsync_low", 32'(vs_cnt), (VSE - VSS) * H);
    check("frame_period", 32'(i2 - i1), FRAME);

    // random writer, fast then slow enough to starve
    mode = 3;
    rate = 90;
    run(FRAME);
    rate = 25;
    run(FRAME);
    rate = 60;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pix_sink.md
Name: pix_sink

Overview:
- Receiving end of the pixel-byte stream produced by the pattern PPU.
- Acts as the strobe/acknowledge responder: accepts bytes into a FIFO, generates 640x480 VGA timing, and drains one byte per active pixel to the 2-bit R/G/B pins.
- Sits between the PPU output handshake and the board VGA pins; clk is the pixel clock.

Parameters:
- DEPTH, 16, FIFO entries.
- ADDR_W, 4, log2(DEPTH).
- PREFILL, 8, minimum level required before streaming starts.
- HA_END, 639, last active column.
- HS_STA, 655, first hsync column.
- HS_END, 751, first column after hsync.
- LINE, 799, last column.
- VA_END, 479, last active line.
- VS_STA, 489, first vsync line.
- VS_END, 491, first line after vsync.
- SCREEN, 524, last line.

Ports:
- clk  in  1  pixel clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- data_i  in  8  pixel byte: [7:6]=R, [5:4]=G, [3:2]=B, [1:0] ignored.
- stb_i  in  1  writer strobe, byte valid.
- ack_o  out  1  registered acknowledge/space-available.
- vga_r, vga_g, vga_b  out  2 each  colour.
- hsync, vsync  out  1 each  negative-polarity sync.
- de  out  1  data enable.
- sx, sy  out  10 each  position of the pixel currently on the pins.
- fifo_level  out  ADDR_W+1  current occupancy.
- underflow_cnt  out  16  starved active pixels, saturating.

Behaviour:
- Reset (rst=1 at posedge):
  - ack_o=0, rgb=0, hsync=1, vsync=1, de=0, sx=sy=0.
  - Counters and FIFO cleared, state=FILL.
  - Reset mid-frame discards all FIFO contents.
- Handshake:
  - A transfer occurs at a posedge when stb_i=1 and ack_o=1; data_i is pushed on that edge.
  - ack_o next = (level_next < DEPTH), where level_next includes the push and pop of the current cycle. This allows back-to-back transfers and uses the full depth.
  - stb_i=1 with ack_o=0: no push; the writer holds the byte.
  - Simultaneous push and pop: level unchanged; push is allowed even at level DEPTH-1.
- Timing counters hc/vc:
  - hc wraps at LINE; vc increments at hc wrap and wraps at SCREEN.
  - Active region: hc<=HA_END and vc<=VA_END.
  - hsync_n asserted (low) for HS_STA<=hc<HS_END; vsync_n for VS_STA<=vc<VS_END.
- Output pipeline:
  - One-stage register. rgb, hsync, vsync, de, sx and sy all reflect the counter value of the previous cycle, and are mutually aligned.
- State machine:
  - FILL:
    - No pops; rgb=0.
    - Goes to STREAM at a cycle where hc=0, vc=0 and level>=PREFILL.
  - STREAM:
    - During active cycles, pop one byte and output its colour bits.
    - If the FIFO is empty in an active cycle: output black, no pop, underflow_cnt+1 (saturates at 16'hFFFF). State remains STREAM, so the stream slips.
    - Blanking cycles never pop and output rgb=0.
- fifo_level is the registered occupancy after each edge.

Optional Feature:
- Macro: PIX_SINK_UNDERFLOW_RESYNC_EN.
- Defined:
  - An underflow in STREAM moves the state to FILL (count still increments).
  - Black for the rest of the frame; FIFO contents are retained.
  - Streaming restarts at the next hc=0, vc=0 with level>=PREFILL, so frame alignment is recovered.
- Undefined: an underflow keeps STREAM as described above.

Test Plan:
- Reset: rst=1 for 2 cycles, stb_i=0 -> reset values as specified; ack_o=1 on the second edge after rst drops; fifo_level=0.
- Backpressure: hold the counters outside frame start with stb_i=1 for 20 cycles and incrementing data -> exactly 16 transfers, ack_o=0 after the 16th, fifo_level=16; bytes 17+ are held and not lost.
- Stream: writer supplies 8'hE4 continuously; frame start reached -> on the cycle after counter (0,0): de=1, vga_r=3, vga_g=2, vga_b=1, sx=0, sy=0; 640 pops per line.
- Underflow: writer stalls 10 active cycles mid-line -> rgb=0 for those 10 pixels, underflow_cnt=10, state STREAM, colour resumes once data arrives.
- Sync: run a full frame -> hsync low for 96 cycles (sx 655..750), vsync low for lines 489..490, de high for 640x480 pixels, frame period 420000 cycles.
- Macro defined: repeat the underflow test -> state FILL, black until the next frame start, then streaming resumes with rgb from the FIFO head.
